serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial adder. Latches two WIDTH-bit operands and adds them one bit per cycle,
//  LSB first, through a single full-adder cell with a registered carry.
//  Sits upstream of the full-adder cell and drives its a/b/c inputs each cycle.
//  Returns the WIDTH-bit sum and carry-out with a start/done handshake.
// PARAMETERS
//  WIDTH  8  operand and sum width in bits; legal range 2..32
// PORTS
//  clk    in   1      single clock; all state updates on the rising edge
//  rst_n  in   1      reset; asynchronous assert, active-low
//  start  in   1      request; sampled only in IDLE or DONE
//  a      in   WIDTH  operand A; sampled on the edge that accepts start
//  b      in   WIDTH  operand B; sampled on the edge that accepts start
//  cin    in   1      carry-in; sampled on the edge that accepts start
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse; sum and cout are valid
//  sum    out  WIDTH  result; holds its value until the next completion
//  cout   out  1      carry-out of the MSB; holds with sum
// BEHAVIOUR
//  Reset (rst_n=0, any time, asynchronous):
//  - state=IDLE, cnt=0, carry=0, shift regs=0.
//  - busy=0, done=0, sum=0, cout=0.
//  - An operation in flight is discarded with no done pulse.
//  FSM states: IDLE, RUN, DONE.
//  - IDLE -start-> RUN. The accepting edge loads a_sr=a, b_sr=b, carry=cin, cnt=0.
//  - RUN, every edge:
//    - {co,s} = FA(a_sr[0], b_sr[0], carry).
//    - Shift a_sr and b_sr right by 1. Shift s into the MSB of s_sr. carry<=co. cnt++.
//  - RUN -> DONE on the edge where cnt==WIDTH-1, i.e. after exactly WIDTH RUN edges.
//    - That same edge sets sum<=final s_sr (including this bit) and cout<=co.
//  - DONE: done=1 for exactly one cycle. Then go to IDLE, or to RUN if start=1
//    (back-to-back; the new operands load on that edge).
//  Handshake and timing:
//  - start while in RUN is ignored; no queueing.
//  - Latency: start accepted at edge E0 -> done high between edges E0+WIDTH and E0+WIDTH+1.
//  - Throughput: one add per WIDTH+1 cycles.
//  Arithmetic and width rules:
//  - Unsigned arithmetic: {cout,sum} = a+b+cin exactly, mod 2^(WIDTH+1).
//  - cnt is $clog2(WIDTH) bits and never wraps past WIDTH-1.
//  - sum and cout change only on the RUN->DONE edge or on reset.
// CONFIGURATION
//  SERIAL_ADDER_OVF_EN defined:
//  - Adds output ovf (1 bit). ovf = carry into MSB XOR carry out of MSB (signed overflow).
//  - ovf is captured with sum/cout, held with them, and reset to 0.
//  SERIAL_ADDER_OVF_EN undefined:
//  - No ovf port and no extra flop. All other behaviour is identical.
// STRUCTURE
//  Package serial_adder_pkg: state enum {IDLE=2'd0, RUN=2'd1, DONE=2'd2}, WIDTH_MAX=32.
//  Sub-module fa_cell: purely combinational full adder, inputs (a,b,c), outputs (s,co).
//  - Instantiated once.
//  - All sequencing, shift registers and the carry flop stay in serial_adder.
// TESTING (WIDTH=8 unless noted)
//  - 0x35+0x4A, cin=0 -> done exactly 8 edges after the accepting edge; sum=0x7F, cout=0.
//  - 0xFF+0x01, cin=0 -> sum=0x00, cout=1, ovf=0; then 0xFF+0x00, cin=1 -> sum=0x00, cout=1.
//  - 0x7F+0x01, cin=0 -> sum=0x80, cout=0, ovf=1 (with OVF_EN); no ovf port without it.
//  - start pulses mid-RUN with other operands -> ignored; result is from the first operands; one done only.
//  - start held high through DONE -> second add begins with no IDLE cycle; both results correct and spaced 9 cycles apart.
//  - rst_n low at RUN cycle 4 -> all outputs 0 immediately (async), no done; a fresh add afterwards is correct.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and limits for the bit-serial adder.
//   state_e    FSM encoding {IDLE, RUN, DONE}
//   WIDTH_MAX  largest supported operand width
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/fa_cell.sv
// fa_cell: purely combinational one-bit full adder.
// Ports:
//   a, b  in   addend bits
//   c     in   carry in
//   s     out  sum bit
//   co    out  carry out
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder. Latches two WIDTH-bit operands and a
// carry-in on an accepted start, then adds one bit per cycle (LSB first) through a
// single fa_cell with a registered carry. Result returns with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf output (signed overflow).
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled in IDLE or DONE only
//   a, b   in   WIDTH-bit operands, sampled on the accepting edge
//   cin    in   carry in, sampled on the accepting edge
//   busy   out  high while adding
//   done   out  one-cycle pulse when sum/cout are updated
//   sum    out  WIDTH-bit result, held until the next completion
//   cout   out  carry out of the MSB, held with sum
//   ovf    out  (SERIAL_ADDER_OVF_EN only) carry into MSB xor carry out of MSB
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_adder: WIDTH out of range");
   end

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   // Only WIDTH-1 earlier sum bits need storing; the last bit comes straight from the cell.
   logic [WIDTH-2:0] s_sr_q, s_sr_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic fa_s, fa_co;

   fa_cell u_fa_cell (
      .a  (a_sr_q[0]),
      .b  (b_sr_q[0]),
      .c  (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (start) begin
               state_d = RUN;
               busy_d  = 1'b1;
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = cin;
               cnt_d   = '0;
            end
         end
         RUN: begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            s_sr_d  = {fa_s, s_sr_q} >> 1;
            carry_d = fa_co;
            if (cnt_q == LastCnt) begin
               // Final bit: cnt holds rather than wrapping.
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               sum_d   = {fa_s, s_sr_q};
               cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = carry_q ^ fa_co;
`endif
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed scoreboard bench for serial_adder (WIDTH=8).
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf   (ovf),
`endif
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W:0] res;   // {cout, sum}
      logic       ovf;
      int         due;   // negedge index on which done must be seen
      string      name;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   neg_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per observed done pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         neg_cnt++;
         if (rst_n === 1'b1 && done === 1'b1) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 at negedge %0d, expected none", neg_cnt);
            end else begin
               e = q.pop_front();
               chk({e.name, "_result"}, {23'd0, cout, sum}, {23'd0, e.res});
               chk({e.name, "_latency"}, neg_cnt, e.due);
`ifdef SERIAL_ADDER_OVF_EN
               chk({e.name, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
`endif
            end
         end
      end
   end

   // Drives one request for a single cycle; optionally records its expectation.
   task automatic issue(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic push, input logic [W:0] res,
                        input logic ov);
      exp_t e;
      @(negedge clk);
      a     = av;
      b     = bv;
      cin   = ci;
      start = 1'b1;
      @(posedge clk);
      if (push) begin
         e.res  = res;
         e.ovf  = ov;
         e.due  = neg_cnt + W + 1;
         e.name = name;
         q.push_back(e);
      end
      #1;
      start = 1'b0;
      chk({name, "_busy"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk({name, "_drained"}, q.size(), 32'd0);
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_sum", {24'd0, sum}, 32'd0);
      chk("reset_cout", {31'd0, cout}, 32'd0);
      rst_n = 1'b1;

      issue("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b1, 9'h07F, 1'b0);
      drain("add_35_4a");
      issue("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b1, 9'h100, 1'b0);
      drain("add_ff_01");
      issue("add_ff_00_c1", 8'hFF, 8'h00, 1'b1, 1'b1, 9'h100, 1'b0);
      drain("add_ff_00_c1");
      issue("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b1, 9'h080, 1'b1);
      drain("add_7f_01");

      // A start pulse with other operands during RUN must be ignored.
      issue("mid_run", 8'h12, 8'h34, 1'b0, 1'b1, 9'h046, 1'b0);
      repeat (2) @(negedge clk);
      a     = 8'hAA;
      b     = 8'h55;
      cin   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain("mid_run");

      // Start held high through DONE: second add loads with no IDLE cycle.
      @(negedge clk);
      a     = 8'h80;
      b     = 8'h80;
      cin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      e.res = 9'h100; e.ovf = 1'b1; e.due = neg_cnt + W + 1; e.name = "b2b_first";
      q.push_back(e);
      e.res = 9'h101; e.ovf = 1'b0; e.due = neg_cnt + 2 * (W + 1); e.name = "b2b_second";
      q.push_back(e);
      #1;
      a   = 8'h0F;
      b   = 8'hF1;
      cin = 1'b1;
      repeat (W + 1) @(posedge clk);
      #1;
      start = 1'b0;
      drain("b2b");

      // Asynchronous reset in the middle of RUN discards the operation.
      issue("rst_mid", 8'hC3, 8'h3C, 1'b0, 1'b0, 9'h000, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      chk("async_rst_done", {31'd0, done}, 32'd0);
      chk("async_rst_sum", {24'd0, sum}, 32'd0);
      chk("async_rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("async_rst_ovf", {31'd0, ovf}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 2) @(negedge clk);
      chk("rst_no_done_queue", q.size(), 32'd0);

      issue("after_rst", 8'h5A, 8'hA5, 1'b1, 1'b1, 9'h100, 1'b0);
      drain("after_rst");
      // Result holds after the done pulse.
      repeat (3) @(negedge clk);
      chk("hold_sum", {23'd0, cout, sum}, 32'h100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
